mc_control_unit: RTL and testbench

Multicycle successor to the single-cycle main/aux decoder pair. Decodes opcode/funct once per instruction and sequences the datapath through fetch, decode, execute, memory and writeback states. Stalls on a memory ready handshake and on a parametrised-latency multiply unit. Sits between the instruction register and the shared multicycle datapath: PC, single memory port, register file, ALU and HI/LO pair.

---
 rtl/mc_control_unit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle control unit: decodes the instruction register once per
// instruction and sequences the shared datapath through fetch, decode,
// execute, memory and writeback. Memory accesses stall on mem_ready and
// MULTU stalls for MULT_LATENCY cycles on an internal down-counter.
module mc_control_unit #(
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_re,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       reg_dst,
   output logic       rf_we,
   output logic [2:0] rf_wd_src,
   output logic       we_r64,
   output logic       busy,
   output logic       illegal
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   // ALU control codes
   localparam logic [2:0] ALU_AND   = 3'b000;
   localparam logic [2:0] ALU_OR    = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_MULTU = 3'b011;
   localparam logic [2:0] ALU_SLL   = 3'b100;
   localparam logic [2:0] ALU_SRL   = 3'b101;
   localparam logic [2:0] ALU_SUB   = 3'b110;
   localparam logic [2:0] ALU_SLT   = 3'b111;

   // Register-file write-data selects
   localparam logic [2:0] WD_ALUOUT = 3'b000;
   localparam logic [2:0] WD_PC4    = 3'b001;
   localparam logic [2:0] WD_LO     = 3'b010;
   localparam logic [2:0] WD_HI     = 3'b011;
   localparam logic [2:0] WD_MEM    = 3'b100;

   // Counter preload so that the last MULT cycle is the one where it reads zero
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

   // Five-bit encoding leaves spare codes; any of them falls back to FETCH
   typedef enum logic [4:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
      S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH,
      S_JUMP, S_JR, S_MULT, S_WB_HILO, S_TRAP
   } state_t;

   state_t           state_q;
   state_t           state_d;
   state_t           dec_state;
   logic [2:0]       dec_alu;
   logic [2:0]       alu_r_q;
   logic             is_load_q;
   logic             is_jal_q;
   logic             is_hi_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mult_done;

   assign mult_done = (cnt_q == '0);

   // Instruction decode: picks the post-DECODE state and the R-type ALU op
   always_comb begin
      dec_state = S_TRAP;
      dec_alu   = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:   begin dec_state = S_EXEC_R; dec_alu = ALU_ADD; end
               FN_SUB:   begin dec_state = S_EXEC_R; dec_alu = ALU_SUB; end
               FN_AND:   begin dec_state = S_EXEC_R; dec_alu = ALU_AND; end
               FN_OR:    begin dec_state = S_EXEC_R; dec_alu = ALU_OR;  end
               FN_SLT:   begin dec_state = S_EXEC_R; dec_alu = ALU_SLT; end
               FN_SLL:   begin dec_state = S_EXEC_R; dec_alu = ALU_SLL; end
               FN_SRL:   begin dec_state = S_EXEC_R; dec_alu = ALU_SRL; end
               FN_JR:    dec_state = S_JR;
               FN_MULTU: dec_state = S_MULT;
               FN_MFHI,
               FN_MFLO:  dec_state = S_WB_HILO;
               default:  dec_state = S_TRAP;
            endcase
         end
         OP_ADDI:      dec_state = S_EXEC_I;
         OP_LW, OP_SW: dec_state = S_MEM_ADDR;
         OP_BEQ:       dec_state = S_BRANCH;
         OP_J, OP_JAL: dec_state = S_JUMP;
         default:      dec_state = S_TRAP;
      endcase
   end

   // Capture the decode results once so later states do not re-decode the IR
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_r_q   <= ALU_ADD;
         is_load_q <= 1'b0;
         is_jal_q  <= 1'b0;
         is_hi_q   <= 1'b0;
      end else if (state_q == S_DECODE) begin
         alu_r_q   <= dec_alu;
         is_load_q <= (opcode == OP_LW);
         is_jal_q  <= (opcode == OP_JAL);
         is_hi_q   <= (funct == FN_MFHI);
      end
   end

   // Multiply latency counter: preload on entry to MULT, count down inside it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == S_DECODE && dec_state == S_MULT) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == S_MULT && !mult_done) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore output decode; everything idles at zero by default
   always_comb begin
      state_d   = state_q;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_ctrl  = ALU_AND;
      reg_dst   = 1'b0;
      rf_we     = 1'b0;
      rf_wd_src = WD_ALUOUT;
      we_r64    = 1'b0;
      illegal   = 1'b0;
      busy      = (state_q != S_FETCH);
      case (state_q)
         S_FETCH: begin
            mem_re    = 1'b1;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_ADD;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_ctrl  = ALU_ADD;
            state_d   = dec_state;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_ctrl  = alu_r_q;
            state_d   = S_WB_R;
         end
         S_WB_R: begin
            rf_we     = 1'b1;
            reg_dst   = 1'b1;
            rf_wd_src = WD_ALUOUT;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            state_d   = S_WB_I;
         end
         S_WB_I: begin
            rf_we     = 1'b1;
            rf_wd_src = WD_ALUOUT;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            state_d   = is_load_q ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_re = 1'b1;
            iord   = 1'b1;
            if (mem_ready) begin
               state_d = S_WB_MEM;
            end
         end
         S_WB_MEM: begin
            rf_we     = 1'b1;
            rf_wd_src = WD_MEM;
            state_d   = S_FETCH;
         end
         S_MEM_WR: begin
            mem_we = 1'b1;
            iord   = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = 2'b01;
            pc_we     = alu_zero;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            state_d = S_FETCH;
            if (is_jal_q) begin
               rf_we     = 1'b1;
               rf_wd_src = WD_PC4;
            end
         end
         S_JR: begin
            pc_we   = 1'b1;
            pc_src  = 2'b11;
            state_d = S_FETCH;
         end
         S_MULT: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_MULTU;
            if (mult_done) begin
               we_r64  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WB_HILO: begin
            rf_we     = 1'b1;
            reg_dst   = 1'b1;
            rf_wd_src = is_hi_q ? WD_HI : WD_LO;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: one instance with MULT_LATENCY=4 and one
// with MULT_LATENCY=1. Per-cycle vectors carry inputs plus the expected Moore
// outputs; expectations go through a scoreboard queue and are compared
// one time unit after the driving falling edge.
module tb_mc_control_unit;

   typedef struct packed {
      logic       mem_re;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic       reg_dst;
      logic       rf_we;
      logic [2:0] rf_wd_src;
      logic       we_r64;
      logic       busy;
      logic       illegal;
   } out_t;

   typedef struct {
      bit         which;
      logic       rst_n;
      logic [5:0] opcode;
      logic [5:0] funct;
      logic       alu_zero;
      logic       mem_ready;
      out_t       exp;
      string      name;
   } vec_t;

   typedef struct {
      bit    which;
      out_t  exp;
      string name;
   } sb_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MULT = 6'b011001;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;

   logic clk;
   logic       rst_n_a, rst_n_b;
   logic [5:0] opcode_a, opcode_b, funct_a, funct_b;
   logic       alu_zero_a, alu_zero_b, mem_ready_a, mem_ready_b;

   logic       a_mem_re, a_mem_we, a_iord, a_ir_we, a_pc_we, a_alu_src_a;
   logic [1:0] a_pc_src, a_alu_src_b;
   logic [2:0] a_alu_ctrl, a_rf_wd_src;
   logic       a_reg_dst, a_rf_we, a_we_r64, a_busy, a_illegal;
   logic       b_mem_re, b_mem_we, b_iord, b_ir_we, b_pc_we, b_alu_src_a;
   logic [1:0] b_pc_src, b_alu_src_b;
   logic [2:0] b_alu_ctrl, b_rf_wd_src;
   logic       b_reg_dst, b_rf_we, b_we_r64, b_busy, b_illegal;

   out_t act_a, act_b;
   vec_t vecs[$];
   sb_t  sb_q[$];
   int   num_checks = 0;
   int   num_fail   = 0;

   bit         cur_dut;
   logic [5:0] cur_op, cur_fn;

   mc_control_unit #(.MULT_LATENCY(4), .CNT_W(3)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .opcode(opcode_a), .funct(funct_a),
      .alu_zero(alu_zero_a), .mem_ready(mem_ready_a),
      .mem_re(a_mem_re), .mem_we(a_mem_we), .iord(a_iord), .ir_we(a_ir_we),
      .pc_we(a_pc_we), .pc_src(a_pc_src), .alu_src_a(a_alu_src_a),
      .alu_src_b(a_alu_src_b), .alu_ctrl(a_alu_ctrl), .reg_dst(a_reg_dst),
      .rf_we(a_rf_we), .rf_wd_src(a_rf_wd_src), .we_r64(a_we_r64),
      .busy(a_busy), .illegal(a_illegal)
   );

   mc_control_unit #(.MULT_LATENCY(1), .CNT_W(1)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .opcode(opcode_b), .funct(funct_b),
      .alu_zero(alu_zero_b), .mem_ready(mem_ready_b),
      .mem_re(b_mem_re), .mem_we(b_mem_we), .iord(b_iord), .ir_we(b_ir_we),
      .pc_we(b_pc_we), .pc_src(b_pc_src), .alu_src_a(b_alu_src_a),
      .alu_src_b(b_alu_src_b), .alu_ctrl(b_alu_ctrl), .reg_dst(b_reg_dst),
      .rf_we(b_rf_we), .rf_wd_src(b_rf_wd_src), .we_r64(b_we_r64),
      .busy(b_busy), .illegal(b_illegal)
   );

   assign act_a = {a_mem_re, a_mem_we, a_iord, a_ir_we, a_pc_we, a_pc_src,
                   a_alu_src_a, a_alu_src_b, a_alu_ctrl, a_reg_dst, a_rf_we,
                   a_rf_wd_src, a_we_r64, a_busy, a_illegal};
   assign act_b = {b_mem_re, b_mem_we, b_iord, b_ir_we, b_pc_we, b_pc_src,
                   b_alu_src_a, b_alu_src_b, b_alu_ctrl, b_reg_dst, b_rf_we,
                   b_rf_wd_src, b_we_r64, b_busy, b_illegal};

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output patterns for each controller state
   function automatic out_t o_fetch(logic rdy);
      out_t o = '0;
      o.mem_re = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
      o.ir_we = rdy; o.pc_we = rdy;
      return o;
   endfunction
   function automatic out_t o_decode();
      out_t o = '0;
      o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_exec_r(logic [2:0] ctrl);
      out_t o = '0;
      o.alu_src_a = 1'b1; o.alu_ctrl = ctrl; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_addr();
      out_t o = '0;
      o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_wb(logic dst, logic [2:0] wd);
      out_t o = '0;
      o.rf_we = 1'b1; o.reg_dst = dst; o.rf_wd_src = wd; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_mem(logic wr);
      out_t o = '0;
      o.mem_re = ~wr; o.mem_we = wr; o.iord = 1'b1; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_branch(logic z);
      out_t o = '0;
      o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
      o.pc_we = z; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_jump(logic link);
      out_t o = '0;
      o.pc_we = 1'b1; o.pc_src = 2'b10; o.busy = 1'b1;
      o.rf_we = link; o.rf_wd_src = link ? 3'b001 : 3'b000;
      return o;
   endfunction
   function automatic out_t o_jr();
      out_t o = '0;
      o.pc_we = 1'b1; o.pc_src = 2'b11; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_mult(logic last);
      out_t o = '0;
      o.alu_src_a = 1'b1; o.alu_ctrl = 3'b011; o.we_r64 = last; o.busy = 1'b1;
      return o;
   endfunction
   function automatic out_t o_trap();
      out_t o = '0;
      o.illegal = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   // Select the target instance and the instruction held in the IR
   task automatic instr(input bit d, input logic [5:0] op, input logic [5:0] fn);
      cur_dut = d; cur_op = op; cur_fn = fn;
   endtask

   // Append one cycle of stimulus and expectation
   task automatic step(input logic rst, input logic z, input logic rdy,
                       input out_t e, input string nm);
      vec_t v;
      v.which = cur_dut; v.rst_n = rst; v.opcode = cur_op; v.funct = cur_fn;
      v.alu_zero = z; v.mem_ready = rdy; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endtask

   // Shorthand for the common fetch + decode prefix with memory ready
   task automatic fd(input string nm);
      step(1'b1, 1'b0, 1'b1, o_fetch(1'b1), {nm, ".fetch"});
      step(1'b1, 1'b0, 1'b1, o_decode(),    {nm, ".decode"});
   endtask

   task automatic build_vectors();
      logic [5:0] r_fn [7]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b000000, 6'b000010};
      logic [2:0] r_ctrl [7] = '{3'b010, 3'b110, 3'b000, 3'b001,
                                 3'b111, 3'b100, 3'b101};
      string      r_nm [7]   = '{"add", "sub", "and", "or", "slt", "sll", "srl"};

      // MULT_LATENCY=1 instance: single MULT cycle, then mfhi
      instr(1'b1, OP_R, FN_MULT);
      fd("b_multu");
      step(1'b1, 1'b0, 1'b1, o_mult(1'b1), "b_multu.mult_only");
      instr(1'b1, OP_R, FN_MFHI);
      fd("b_mfhi");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b1, 3'b011), "b_mfhi.wb");

      // R-type ALU ops, 4 cycles each
      for (int i = 0; i < 7; i++) begin
         instr(1'b0, OP_R, r_fn[i]);
         fd(r_nm[i]);
         step(1'b1, 1'b0, 1'b1, o_exec_r(r_ctrl[i]), {r_nm[i], ".exec"});
         step(1'b1, 1'b0, 1'b1, o_wb(1'b1, 3'b000), {r_nm[i], ".wb"});
      end

      instr(1'b0, OP_ADDI, 6'b000000);
      fd("addi");
      step(1'b1, 1'b0, 1'b1, o_addr(), "addi.exec");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b0, 3'b000), "addi.wb");

      // sw with one stalled write cycle
      instr(1'b0, OP_SW, 6'b101010);
      fd("sw");
      step(1'b1, 1'b0, 1'b1, o_addr(),     "sw.addr");
      step(1'b1, 1'b0, 1'b0, o_mem(1'b1),  "sw.wr_wait");
      step(1'b1, 1'b0, 1'b1, o_mem(1'b1),  "sw.wr_done");

      // lw with three stalled read cycles: 8 cycles total
      instr(1'b0, OP_LW, 6'b000000);
      fd("lw_wait");
      step(1'b1, 1'b0, 1'b1, o_addr(), "lw_wait.addr");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b0, o_mem(1'b0), "lw_wait.rd_stall");
      step(1'b1, 1'b0, 1'b1, o_mem(1'b0), "lw_wait.rd_done");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b0, 3'b100), "lw_wait.wb");

      // Fetch stalled two cycles, then j
      instr(1'b0, OP_J, 6'b000000);
      step(1'b1, 1'b0, 1'b0, o_fetch(1'b0), "j.fetch_stall");
      step(1'b1, 1'b0, 1'b0, o_fetch(1'b0), "j.fetch_stall");
      fd("j");
      step(1'b1, 1'b0, 1'b1, o_jump(1'b0), "j.jump");

      instr(1'b0, OP_BEQ, 6'b000000);
      fd("beq_taken");
      step(1'b1, 1'b1, 1'b1, o_branch(1'b1), "beq_taken.branch");
      fd("beq_not");
      step(1'b1, 1'b0, 1'b1, o_branch(1'b0), "beq_not.branch");

      instr(1'b0, OP_JAL, 6'b000000);
      fd("jal");
      step(1'b1, 1'b0, 1'b1, o_jump(1'b1), "jal.jump");

      instr(1'b0, OP_R, FN_JR);
      fd("jr");
      step(1'b1, 1'b0, 1'b1, o_jr(), "jr.jr");

      // multu with latency 4: we_r64 only in cycle 6
      instr(1'b0, OP_R, FN_MULT);
      fd("multu");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b1, o_mult(1'b0), "multu.mult_busy");
      step(1'b1, 1'b0, 1'b1, o_mult(1'b1), "multu.mult_last");
      instr(1'b0, OP_R, FN_MFHI);
      fd("mfhi");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b1, 3'b011), "mfhi.wb");
      instr(1'b0, OP_R, FN_MFLO);
      fd("mflo");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b1, 3'b010), "mflo.wb");

      // Reset held for two edges in the middle of a multiply
      instr(1'b0, OP_R, FN_MULT);
      fd("rst_mult");
      step(1'b1, 1'b0, 1'b1, o_mult(1'b0), "rst_mult.mult1");
      step(1'b0, 1'b0, 1'b0, o_mult(1'b0), "rst_mult.mult2_in_reset");
      step(1'b0, 1'b0, 1'b0, o_fetch(1'b0), "rst_mult.fetch_in_reset");
      step(1'b1, 1'b0, 1'b0, o_fetch(1'b0), "rst_mult.fetch_released");
      fd("rst_mult_again");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b1, o_mult(1'b0), "rst_mult_again.mult_busy");
      step(1'b1, 1'b0, 1'b1, o_mult(1'b1), "rst_mult_again.mult_last");

      // Reset during a stalled memory read
      instr(1'b0, OP_LW, 6'b000000);
      fd("rst_lw");
      step(1'b1, 1'b0, 1'b1, o_addr(),    "rst_lw.addr");
      step(1'b1, 1'b0, 1'b0, o_mem(1'b0), "rst_lw.rd_stall");
      step(1'b0, 1'b0, 1'b1, o_mem(1'b0), "rst_lw.rd_in_reset");
      fd("rst_lw_again");
      step(1'b1, 1'b0, 1'b1, o_addr(),    "rst_lw_again.addr");
      step(1'b1, 1'b0, 1'b1, o_mem(1'b0), "rst_lw_again.rd");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b0, 3'b100), "rst_lw_again.wb");

      // Unknown R-type funct traps
      instr(1'b0, OP_R, 6'b111111);
      fd("bad_funct");
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 1'b1, o_trap(), "bad_funct.trap");
      step(1'b0, 1'b0, 1'b0, o_trap(), "bad_funct.trap_in_reset");

      // Illegal opcode: trap for 20 cycles regardless of inputs, then reset
      instr(1'b0, OP_BAD, 6'b000000);
      step(1'b1, 1'b0, 1'b1, o_fetch(1'b1), "bad_op.fetch");
      step(1'b1, 1'b0, 1'b1, o_decode(),    "bad_op.decode");
      for (int i = 0; i < 20; i++) begin
         if (i == 10) instr(1'b0, OP_LW, 6'b000000);
         step(1'b1, 1'(i % 2), 1'(i % 3 != 0), o_trap(), "bad_op.trap_hold");
      end
      step(1'b0, 1'b0, 1'b0, o_trap(),      "bad_op.trap_in_reset");
      step(1'b1, 1'b0, 1'b0, o_fetch(1'b0), "bad_op.fetch_after_reset");
      instr(1'b0, OP_R, 6'b100000);
      fd("add_after_trap");
      step(1'b1, 1'b0, 1'b1, o_exec_r(3'b010), "add_after_trap.exec");
      step(1'b1, 1'b0, 1'b1, o_wb(1'b1, 3'b000), "add_after_trap.wb");
   endtask

   // Drive one cycle of inputs at the falling edge and queue its expectation
   task automatic applyStimulus(input vec_t v);
      sb_t e;
      @(negedge clk);
      if (v.which) begin
         rst_n_b = v.rst_n; opcode_b = v.opcode; funct_b = v.funct;
         alu_zero_b = v.alu_zero; mem_ready_b = v.mem_ready;
      end else begin
         rst_n_a = v.rst_n; opcode_a = v.opcode; funct_a = v.funct;
         alu_zero_a = v.alu_zero; mem_ready_a = v.mem_ready;
      end
      e.which = v.which; e.exp = v.exp; e.name = v.name;
      sb_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against the selected instance
   task automatic checkOutput();
      sb_t  e;
      out_t act;
      #1;
      num_checks++;
      if (sb_q.size() == 0) begin
         num_fail++;
         $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
         return;
      end
      e   = sb_q.pop_front();
      act = e.which ? act_b : act_a;
      if (act !== e.exp) begin
         num_fail++;
         $display("[TB] FAIL %s (dut %0d) at %0t: got %b required %b",
                  e.name, e.which, $time, act, e.exp);
      end
   endtask

   // Main sequence: reset both instances, then play the vector table
   initial begin
      rst_n_a = 1'b0; rst_n_b = 1'b0;
      opcode_a = '0; opcode_b = '0; funct_a = '0; funct_b = '0;
      alu_zero_a = 1'b0; alu_zero_b = 1'b0;
      mem_ready_a = 1'b0; mem_ready_b = 1'b0;
      build_vectors();
      repeat (2) @(posedge clk);
      $display("[TB] applying %0d vectors", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
